// File: rtl/host_packet_pkg.sv
// Shared types, defaults and lane helper for the host packet packer.
package host_packet_pkg;

    localparam int unsigned DEF_WORD_BYTES = 4;
    localparam int unsigned DEF_DEPTH      = 512;

    typedef enum logic {
        PACK = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Bit offset of the lane that receives byte number idx of a word.
    function automatic int unsigned lane_offset(input int unsigned idx,
                                                input int unsigned nbytes,
                                                input bit          big);
        return big ? (nbytes - 1 - idx) * 8 : idx * 8;
    endfunction

endpackage

// File: rtl/host_packet_fifo.sv
// Synchronous packet FIFO with count, sticky underflow and a registered read port.
// Define HOST_PACKET_FWFT_EN for first-word fall-through reads.
module host_packet_fifo
    import host_packet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_BYTES * 8 + 1,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             underflow_q;
    logic             wr_c;
    logic             pop_c;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign count_o     = count_q;
    assign underflow_o = underflow_q;
    // Flags come from the registered count, so a pop never frees space in its own cycle.
    assign wr_c        = wr_en_i && !full_o;
    assign pop_c       = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            underflow_q <= underflow_q | (rd_en_i & empty_o);
        end
    end

`ifdef HOST_PACKET_FWFT_EN
    assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign rd_valid_o = !empty_o;
`else
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pop_c;
            if (pop_c) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: rtl/host_packet_packer.sv
// Packs a byte stream into WORD_BYTES-wide host packets and buffers them in a FIFO.
// HOST_PACKET_FWFT_EN selects first-word fall-through on the read side.
module host_packet_packer
    import host_packet_pkg::*;
#(
    parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic                      clk100,
    input  logic                      rst,
    input  logic [7:0]                byte_data,
    input  logic                      byte_valid,
    input  logic                      byte_last,
    output logic                      byte_ready,
    input  logic                      hostPacketFIFOReadEn,
    output logic [WORD_BYTES*8-1:0]   hostPacketFIFORead_packet,
    output logic                      hostPacketFIFORead_last,
    output logic                      hostPacketFIFORead_valid,
    output logic                      hostPacketFIFORead_empty,
    output logic [$clog2(DEPTH):0]    hostPacketFIFORead_count,
    output logic                      underflow
);

    localparam int unsigned WW = WORD_BYTES * 8;
    localparam int unsigned LW = $clog2(WORD_BYTES);

    state_e          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [WW-1:0]   word_q, word_d;
    logic [WW-1:0]   hold_data_q, hold_data_d;
    logic            hold_last_q, hold_last_d;
    logic            ready_q, ready_d;

    logic            accept_c;
    logic            complete_c;
    logic [WW-1:0]   assembled_c;
    logic            wr_en_c;
    logic [WW:0]     wr_data_c;
    logic [WW:0]     rd_data_c;
    logic            full_c;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q     <= PACK;
            lane_q      <= '0;
            word_q      <= {WORD_BYTES{PAD_BYTE}};
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            ready_q     <= ready_d;
        end
    end

    // word_q keeps unfilled lanes at PAD_BYTE so a flushed partial word needs no masking.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        wr_en_c     = 1'b0;
        wr_data_c   = '0;

        accept_c    = byte_valid && ready_q && (state_q == PACK);
        complete_c  = accept_c && ((lane_q == LW'(WORD_BYTES - 1)) || byte_last);
        assembled_c = word_q;
        assembled_c[lane_offset(32'(lane_q), WORD_BYTES, BIG_ENDIAN) +: 8] = byte_data;

        unique case (state_q)
            PACK: begin
                if (complete_c) begin
                    lane_d = '0;
                    word_d = {WORD_BYTES{PAD_BYTE}};
                    if (!full_c) begin
                        wr_en_c   = 1'b1;
                        wr_data_c = {assembled_c, byte_last};
                    end else begin
                        hold_data_d = assembled_c;
                        hold_last_d = byte_last;
                        state_d     = HOLD;
                    end
                end else if (accept_c) begin
                    lane_d = lane_q + LW'(1);
                    word_d = assembled_c;
                end
            end
            HOLD: begin
                if (!full_c) begin
                    wr_en_c   = 1'b1;
                    wr_data_c = {hold_data_q, hold_last_q};
                    state_d   = PACK;
                end
            end
            default: state_d = PACK;
        endcase

        ready_d = (state_d == PACK);
    end

    host_packet_fifo #(
        .WIDTH (WW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk100),
        .rst         (rst),
        .wr_en_i     (wr_en_c),
        .wr_data_i   (wr_data_c),
        .rd_en_i     (hostPacketFIFOReadEn),
        .rd_data_o   (rd_data_c),
        .rd_valid_o  (hostPacketFIFORead_valid),
        .empty_o     (hostPacketFIFORead_empty),
        .full_o      (full_c),
        .count_o     (hostPacketFIFORead_count),
        .underflow_o (underflow)
    );

    assign byte_ready                = ready_q;
    assign hostPacketFIFORead_packet = rd_data_c[WW:1];
    assign hostPacketFIFORead_last   = rd_data_c[0];

endmodule

// File: tb/tb_host_packet_packer.sv
// Directed bench for host_packet_packer: big- and little-endian instances share one stimulus stream.
module tb_host_packet_packer;
    import host_packet_pkg::*;

    logic        clk100;
    logic        rst;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_last;
    logic        rd_en;

    logic        be_ready, be_last, be_valid, be_empty, be_underflow;
    logic [31:0] be_packet;
    logic [2:0]  be_count;
    logic        le_ready, le_last, le_valid, le_empty, le_underflow;
    logic [31:0] le_packet;
    logic [2:0]  le_count;

    int total = 0;
    int bad   = 0;

    host_packet_packer #(
        .WORD_BYTES (4), .DEPTH (4), .BIG_ENDIAN (1'b1), .PAD_BYTE (8'hEE)
    ) dut_be (
        .clk100                    (clk100),
        .rst                       (rst),
        .byte_data                 (byte_data),
        .byte_valid                (byte_valid),
        .byte_last                 (byte_last),
        .byte_ready                (be_ready),
        .hostPacketFIFOReadEn      (rd_en),
        .hostPacketFIFORead_packet (be_packet),
        .hostPacketFIFORead_last   (be_last),
        .hostPacketFIFORead_valid  (be_valid),
        .hostPacketFIFORead_empty  (be_empty),
        .hostPacketFIFORead_count  (be_count),
        .underflow                 (be_underflow)
    );

    host_packet_packer #(
        .WORD_BYTES (4), .DEPTH (4), .BIG_ENDIAN (1'b0), .PAD_BYTE (8'hEE)
    ) dut_le (
        .clk100                    (clk100),
        .rst                       (rst),
        .byte_data                 (byte_data),
        .byte_valid                (byte_valid),
        .byte_last                 (byte_last),
        .byte_ready                (le_ready),
        .hostPacketFIFOReadEn      (rd_en),
        .hostPacketFIFORead_packet (le_packet),
        .hostPacketFIFORead_last   (le_last),
        .hostPacketFIFORead_valid  (le_valid),
        .hostPacketFIFORead_empty  (le_empty),
        .hostPacketFIFORead_count  (le_count),
        .underflow                 (le_underflow)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offers one byte and holds it until accepted (bounded wait on byte_ready).
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        byte_data  = d;
        byte_last  = l;
        byte_valid = 1'b1;
        while (!be_ready && n < 50) begin
            @(posedge clk100); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk100); #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], 1'b0);
    endtask

    task automatic pop(input string tag, input logic [31:0] eb, input logic [31:0] el,
                       input bit cl, input logic lst);
`ifdef HOST_PACKET_FWFT_EN
        chk({tag, "_valid"}, 64'(be_valid), 64'd1);
        chk({tag, "_pkt"}, 64'(be_packet), 64'(eb));
        chk({tag, "_last"}, 64'(be_last), 64'(lst));
        if (cl) chk({tag, "_le_pkt"}, 64'(le_packet), 64'(el));
        rd_en = 1'b1;
        @(posedge clk100); #1;
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        @(posedge clk100); #1;
        rd_en = 1'b0;
        chk({tag, "_valid"}, 64'(be_valid), 64'd1);
        chk({tag, "_pkt"}, 64'(be_packet), 64'(eb));
        chk({tag, "_last"}, 64'(be_last), 64'(lst));
        if (cl) chk({tag, "_le_pkt"}, 64'(le_packet), 64'(el));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst        = 1'b1;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        rd_en      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk100);
        #1;
        chk("rst_ready", 64'(be_ready), 64'd0);
        chk("rst_packet", 64'(be_packet), 64'd0);
        chk("rst_last", 64'(be_last), 64'd0);
        chk("rst_valid", 64'(be_valid), 64'd0);
        chk("rst_empty", 64'(be_empty), 64'd1);
        chk("rst_count", 64'(be_count), 64'd0);
        chk("rst_underflow", 64'(be_underflow), 64'd0);
        rst = 1'b0;
        @(posedge clk100); #1;
        chk("ready_after_rst", 64'(be_ready), 64'd1);

        // Byte order
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("order_count", 64'(be_count), 64'd1);
        pop("order", 32'h11223344, 32'h44332211, 1'b1, 1'b0);
        @(posedge clk100); #1;
        chk("order_valid_drop", 64'(be_valid), 64'd0);
`ifndef HOST_PACKET_FWFT_EN
        chk("order_pkt_hold", 64'(be_packet), 64'h11223344);
`endif
        chk("order_empty", 64'(be_empty), 64'd1);

        // Partial flush then a fresh word starting at lane 0
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        pop("partial", 32'hAABBEEEE, 32'hEEEEBBAA, 1'b1, 1'b1);
        send_word(32'h01020304);
        pop("after_partial", 32'h01020304, 32'h04030201, 1'b1, 1'b0);

        // Pop while empty
        rd_en = 1'b1;
        @(posedge clk100); #1;
        rd_en = 1'b0;
        chk("uf_valid", 64'(be_valid), 64'd0);
        chk("uf_flag", 64'(be_underflow), 64'd1);
        chk("uf_count", 64'(be_count), 64'd0);
        repeat (3) @(posedge clk100);
        #1;
        chk("uf_sticky", 64'(be_underflow), 64'd1);

        // Simultaneous write and pop at count=2
        send_word(32'hA0A1A2A3);
        send_word(32'hB0B1B2B3);
        chk("conc_count_pre", 64'(be_count), 64'd2);
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        byte_data  = 8'hC3;
        byte_valid = 1'b1;
        rd_en      = 1'b1;
        @(posedge clk100); #1;
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        chk("conc_count", 64'(be_count), 64'd2);
`ifndef HOST_PACKET_FWFT_EN
        chk("conc_pkt", 64'(be_packet), 64'hA0A1A2A3);
`endif
        pop("conc_b", 32'hB0B1B2B3, 32'h0, 1'b0, 1'b0);
        pop("conc_c", 32'hC0C1C2C3, 32'h0, 1'b0, 1'b0);
        chk("conc_empty", 64'(be_empty), 64'd1);

        // Fill to full: 5 words into a 4-deep FIFO
        for (int k = 0; k < 20; k++) send(8'(8'h40 + k), 1'b0);
        chk("full_count", 64'(be_count), 64'd4);
        chk("full_ready", 64'(be_ready), 64'd0);
        chk("full_state", 64'(dut_be.state_q), 64'(HOLD));
        pop("full_w0", 32'h40414243, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!be_ready && n < 2) begin
            @(posedge clk100); #1;
            n++;
        end
        chk("full_reenable", 64'(be_ready), 64'd1);
        chk("full_count_refill", 64'(be_count), 64'd4);
        pop("full_w1", 32'h44454647, 32'h0, 1'b0, 1'b0);
        pop("full_w2", 32'h48494A4B, 32'h0, 1'b0, 1'b0);
        pop("full_w3", 32'h4C4D4E4F, 32'h0, 1'b0, 1'b0);
        pop("full_w4", 32'h50515253, 32'h0, 1'b0, 1'b0);
        chk("full_drained", 64'(be_empty), 64'd1);

        // Asynchronous reset mid-word
        send(8'h91, 1'b0);
        send(8'h92, 1'b0);
        send(8'h93, 1'b0);
        #3;
        rst = 1'b1;
        #2;
        chk("mid_rst_empty", 64'(be_empty), 64'd1);
        chk("mid_rst_count", 64'(be_count), 64'd0);
        chk("mid_rst_underflow", 64'(be_underflow), 64'd0);
        chk("mid_rst_ready", 64'(be_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk100); #1;
        send_word(32'h61626364);
        pop("post_rst", 32'h61626364, 32'h64636261, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
